// File: rtl/fifo_level_if.sv
// Bus bundle between a FIFO producer/consumer and fifo_level.
// master: the logic that pushes/pops words; slave: the FIFO itself.
interface fifo_level_if #(
    parameter int D_WIDTH    = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  clr;
    logic                  wr;
    logic [D_WIDTH-1:0]    wr_data;
    logic                  rd;
    logic [D_WIDTH-1:0]    rd_data;
    logic                  empty;
    logic                  full;
    logic                  almost_empty;
    logic                  almost_full;
    logic [ADDR_WIDTH:0]   level;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output clr, wr, wr_data, rd,
        input  rd_data, empty, full, almost_empty, almost_full,
               level, overflow, underflow
    );

    modport slave (
        input  clr, wr, wr_data, rd,
        output rd_data, empty, full, almost_empty, almost_full,
               level, overflow, underflow
    );
endinterface

// File: rtl/fifo_level.sv
// Synchronous show-ahead FIFO with occupancy count, almost-full/almost-empty
// thresholds, synchronous flush and sticky overflow/underflow flags.
// All status flags are registered from the next-state level, so no flag has
// a combinational path from wr/rd.
module fifo_level #(
    parameter int D_WIDTH    = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = (2**ADDR_WIDTH) - 2,
    parameter int AE_LEVEL   = 1
) (
    input  logic           clk,
    input  logic           reset_n,
    fifo_level_if.slave    bus
);
    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam int LW    = ADDR_WIDTH + 1;

    localparam logic [LW-1:0] C_DEPTH = LW'(DEPTH);
    localparam logic [LW-1:0] C_AF    = LW'(AF_LEVEL);
    localparam logic [LW-1:0] C_AE    = LW'(AE_LEVEL);

    logic [D_WIDTH-1:0]    r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [LW-1:0]         r_level;
    logic                  r_empty;
    logic                  r_full;
    logic                  r_almost_empty;
    logic                  r_almost_full;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_rd_en;
    logic                  w_wr_en;
    logic [LW-1:0]         w_level_next;

    // A read at full frees a slot in the same edge, so a concurrent write is
    // accepted; a read at empty is always rejected.
    assign w_rd_en = bus.rd & ~r_empty;
    assign w_wr_en = bus.wr & (~r_full | w_rd_en);

    // Next occupancy; simultaneous accepted read+write leaves it unchanged.
    always_comb begin
        w_level_next = r_level;
        if (w_wr_en && !w_rd_en) begin
            w_level_next = r_level + LW'(1);
        end else if (!w_wr_en && w_rd_en) begin
            w_level_next = r_level - LW'(1);
        end
    end

    // Storage array; deliberately not reset, flush leaves contents alone.
    always_ff @(posedge clk) begin
        if (!bus.clr && w_wr_en) begin
            r_mem[r_wr_ptr] <= bus.wr_data;
        end
    end

    // Pointers, level, status flags and sticky error flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_level        <= '0;
            r_empty        <= 1'b1;
            r_full         <= 1'b0;
            r_almost_empty <= 1'b1;
            r_almost_full  <= (C_AF == '0);
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else if (bus.clr) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_level        <= '0;
            r_empty        <= 1'b1;
            r_full         <= 1'b0;
            r_almost_empty <= 1'b1;
            r_almost_full  <= (C_AF == '0);
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            end
            r_level        <= w_level_next;
            r_empty        <= (w_level_next == '0);
            r_full         <= (w_level_next == C_DEPTH);
            r_almost_empty <= (w_level_next <= C_AE);
            r_almost_full  <= (w_level_next >= C_AF);
            if (bus.wr && r_full && !w_rd_en) begin
                r_overflow <= 1'b1;
            end
            if (bus.rd && r_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // Show-ahead head word; meaningless while empty.
    assign bus.rd_data      = r_mem[r_rd_ptr];
    assign bus.empty        = r_empty;
    assign bus.full         = r_full;
    assign bus.almost_empty = r_almost_empty;
    assign bus.almost_full  = r_almost_full;
    assign bus.level        = r_level;
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;
endmodule
